// File: rtl/pong_pkg.sv
// pong_pkg: shared state encodings, winner codes and game defaults for the Pong sequencer
package pong_pkg;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SERVE    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_POINT    = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;
`ifdef PONG_PAUSE_EN
    localparam logic [2:0] ST_PAUSE    = 3'd5;
`endif
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam int DEF_WIN_SCORE    = 5;
    localparam int DEF_SERVE_FRAMES = 60;
endpackage

// File: rtl/pong_round_sequencer_btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer plus registered rising-edge pulse for an async button
// Ports: clock, reset (async, active-high), btn (async level in), pulse (1-cycle pulse, 3 cycles after rise)
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic [2:0] sync_q, sync_d;
    logic       pulse_q, pulse_d;

    // sync_q[1:0] is the synchronizer, sync_q[2] the previous synchronized level
    always_comb begin
        sync_d  = {sync_q[1:0], btn};
        pulse_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/pong_round_sequencer.sv
// pong_round_sequencer: Pong game phase sequencer (serve, play, point, game over) driving the CPU wrapper
// Ports: clock, reset (async, active-high), screen_end, start_btn, winner_in[1:0] in;
//        cpu_reset, frame_tick, score_p1, score_p2, game_winner[1:0], state_o[2:0] out (all registered).
// Define PONG_PAUSE_EN to add pause_btn and the PAUSE state.
module pong_round_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int SCORE_W      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               screen_end,
    input  logic               start_btn,
`ifdef PONG_PAUSE_EN
    input  logic               pause_btn,
`endif
    input  logic [1:0]         winner_in,
    output logic               cpu_reset,
    output logic               frame_tick,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         game_winner,
    output logic [2:0]         state_o
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0]         gw_q, gw_d;
    logic               cpu_reset_q, cpu_reset_d, frame_tick_q, frame_tick_d;
    logic               screen_end_q, scr_edge, start_pulse, pause_pulse;

    btn_sync_edge u_start (.clock(clock), .reset(reset), .btn(start_btn), .pulse(start_pulse));
`ifdef PONG_PAUSE_EN
    btn_sync_edge u_pause (.clock(clock), .reset(reset), .btn(pause_btn), .pulse(pause_pulse));
`else
    assign pause_pulse = 1'b0;
`endif

    assign scr_edge = screen_end & ~screen_end_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        gw_d         = gw_q;
        frame_tick_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAMEOVER: if (start_pulse) begin
                state_d = ST_SERVE;
                cnt_d   = '0;
                p1_d    = '0;
                p2_d    = '0;
                gw_d    = WIN_NONE;
            end
            ST_SERVE: if (scr_edge) begin
                state_d = (cnt_q + 1'b1 == CNT_W'(SERVE_FRAMES)) ? ST_PLAY : ST_SERVE;
                cnt_d   = (cnt_q + 1'b1 == CNT_W'(SERVE_FRAMES)) ? '0 : cnt_q + 1'b1;
            end
            ST_PLAY: begin
                // A point beats a same-cycle frame edge or pause request
                if (winner_in == WIN_P1 || winner_in == WIN_P2) begin
                    state_d = ST_POINT;
                    p1_d    = (winner_in == WIN_P1 && p1_q != WIN_S) ? p1_q + 1'b1 : p1_q;
                    p2_d    = (winner_in == WIN_P2 && p2_q != WIN_S) ? p2_q + 1'b1 : p2_q;
                end else begin
                    frame_tick_d = scr_edge;
`ifdef PONG_PAUSE_EN
                    if (pause_pulse) state_d = ST_PAUSE;
`endif
                end
            end
            ST_POINT: begin
                state_d = (p1_q == WIN_S || p2_q == WIN_S) ? ST_GAMEOVER : ST_SERVE;
                gw_d    = (p1_q == WIN_S) ? WIN_P1 : (p2_q == WIN_S) ? WIN_P2 : WIN_NONE;
            end
`ifdef PONG_PAUSE_EN
            ST_PAUSE: if (pause_pulse) state_d = ST_PLAY;
`endif
            default: state_d = ST_IDLE;
        endcase
        // Registered from the next state so the CPU runs from the very first PLAY cycle
        cpu_reset_d = !(state_d == ST_PLAY
`ifdef PONG_PAUSE_EN
                        || state_d == ST_PAUSE
`endif
                       );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            gw_q         <= WIN_NONE;
            cpu_reset_q  <= 1'b1;
            frame_tick_q <= 1'b0;
            screen_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            gw_q         <= gw_d;
            cpu_reset_q  <= cpu_reset_d;
            frame_tick_q <= frame_tick_d;
            screen_end_q <= screen_end;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign frame_tick  = frame_tick_q;
    assign score_p1    = p1_q;
    assign score_p2    = p2_q;
    assign game_winner = gw_q;
    assign state_o     = state_q;

    logic unused_pause;
    assign unused_pause = pause_pulse;
endmodule

// File: doc/pong_round_sequencer.md
Name: pong_round_sequencer

Overview:
- Top-level game sequencer for the Pong system.
- Owns the processor/regfile reset line and gates the per-frame tick (posEdgeScreenEnd) into the CPU wrapper.
- Tracks per-player scores from the point-winner code that game logic writes to the memory-mapped winner register.
- Runs serve countdown, play, point, and game-over phases between the VGA timing block and the CPU wrapper.

Parameters:
- WIN_SCORE, 5: points needed to win a game; legal range 1 to 2^SCORE_W-1.
- SERVE_FRAMES, 60: screen-end edges spent in SERVE before play resumes; minimum 1.
- SCORE_W, 4: width of each score counter.

Ports:
- clock  in  1  system clock; the single clock domain.
- reset  in  1  asynchronous, active-high reset.
- screen_end  in  1  end-of-frame level from VGA timing; synchronous to clock.
- start_btn  in  1  start/restart push button; asynchronous, active-high.
- winner_in  in  2  point winner from the wrapper's winner output: 00 none, 01 P1, 10 P2, 11 invalid.
- cpu_reset  out  1  drives the wrapper reset input; 1 holds the processor and regfile in reset.
- frame_tick  out  1  one-cycle pulse per screen-end rising edge, emitted only in PLAY; drives posEdgeScreenEnd.
- score_p1  out  SCORE_W  player 1 score.
- score_p2  out  SCORE_W  player 2 score.
- game_winner  out  2  00 game in progress, 01 P1 won, 10 P2 won.
- state_o  out  3  current state encoding, for the display/debug.

Behaviour:
- Reset (async, immediate): state IDLE; cpu_reset=1; frame_tick=0; scores 0; game_winner=00; serve counter 0.
- All outputs are registered.
- Edges:
  - scr_edge = screen_end & ~screen_end_q, where screen_end_q is one register delay.
  - start_btn passes through a 2-FF synchronizer, then rising-edge detection.
  - start_pulse appears 3 cycles after the async rise.
- IDLE: cpu_reset=1. On start_pulse: clear scores and game_winner, clear serve counter, go to SERVE.
- SERVE: cpu_reset=1. The serve counter increments on each scr_edge. At the edge that makes the count equal SERVE_FRAMES, go to PLAY and clear the counter.
- PLAY:
  - cpu_reset=0 from the first PLAY cycle.
  - frame_tick=1 in the cycle after a scr_edge.
  - winner_in is sampled every cycle.
  - On 01 or 10 in cycle N: go to POINT in N+1, increment the matching score in N+1, and drive cpu_reset=1 in N+1.
  - Code 11 is ignored.
- POINT (exactly 1 cycle): cpu_reset=1. If either score equals WIN_SCORE, go to GAMEOVER and set game_winner to that player. Otherwise go to SERVE.
- GAMEOVER: cpu_reset=1; scores and game_winner hold. On start_pulse: clear scores and game_winner, go to SERVE.
- Scores saturate at WIN_SCORE and never wrap.
- Simultaneous events in PLAY:
  - winner_in nonzero and scr_edge together: POINT is taken and frame_tick is suppressed.
  - start_pulse in SERVE, PLAY or POINT is ignored.
- winner_in outside PLAY is ignored. The regfile clears winner while cpu_reset is high, so there is no double count.
- Reset mid-game: all state is lost and the block returns to IDLE; no partial scores are kept.
- Encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4, PAUSE=5.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- Defined:
  - Adds port pause_btn (in, 1, async), passed through the same sync/edge logic as start_btn.
  - A pause_pulse in PLAY goes to PAUSE; in PAUSE it returns to PLAY.
  - In PAUSE: cpu_reset=0 (processor state preserved), frame_tick=0, winner_in ignored.
  - start_pulse in PAUSE is ignored.
- Undefined: no pause_btn port; the PAUSE state and encoding 5 are unreachable and absent.

Decomposition:
- Package pong_pkg holds:
  - state encodings;
  - winner codes (WIN_NONE=00, WIN_P1=01, WIN_P2=10);
  - default WIN_SCORE and SERVE_FRAMES.
- One sub-module, btn_sync_edge: 2-FF synchronizer plus rising-edge pulse, with asynchronous active-high reset to 0. Instantiated for start_btn, and for pause_btn when enabled.

Test Plan:
- Reset, then start_btn held high 10 cycles -> SERVE entered 3-4 cycles after the rise; cpu_reset=1; scores 0.
- SERVE_FRAMES=3; three screen_end pulses -> PLAY on the 3rd edge; cpu_reset=0; the next screen_end edge gives exactly one 1-cycle frame_tick.
- In PLAY, winner_in=01 for 1 cycle -> next cycle score_p1=1, cpu_reset=1, state POINT, then SERVE; winner_in=11 -> no change.
- WIN_SCORE=2; two P2 points -> game_winner=10 and state GAMEOVER; further winner_in ignored; start_btn -> scores 0 and SERVE.
- winner_in=10 and a screen_end edge in the same PLAY cycle -> score_p2 increments once; no frame_tick pulse.
- Reset asserted mid-PLAY with score 3-1 -> outputs return to reset values asynchronously; with PONG_PAUSE_EN defined, pause toggles PLAY/PAUSE, no frame_tick during PAUSE, cpu_reset stays 0.
